db_fsm_tick: RTL

//  Debounces one raw push-button input using the periodic 1-cycle enable pulse from the

---
 rtl/db_fsm_tick_pkg.sv | 15 +
 rtl/db_fsm_tick_if.sv | 25 ++
 rtl/db_fsm_tick_sync_2ff.sv | 28 ++
 rtl/db_fsm_tick.sv | 95 +++++++++
 4 files changed

// File: rtl/db_fsm_tick_pkg.sv
// Shared types and defaults for the tick-enabled push-button debouncer.
// State encodings are fixed so that other blocks and debug tools can decode them.
package db_fsm_tick_pkg;

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_ONE   = 2'd2,
        ST_WAIT0 = 2'd3
    } db_state_t;

    localparam int N_TICKS_DEF = 3;
    localparam int CNT_W_DEF   = 2;

endpackage

// File: rtl/db_fsm_tick_if.sv
// Button-in / debounced-out bundle between the tick generator, the pin and the debouncer.
// The master drives tick and the raw pin; the slave (debouncer) returns the clean signals.
interface db_fsm_tick_if;
    logic tick;
    logic btn_in;
    logic db_level;
    logic db_rise;
    logic db_fall;

    modport master (
        output tick,
        output btn_in,
        input  db_level,
        input  db_rise,
        input  db_fall
    );

    modport slave (
        input  tick,
        input  btn_in,
        output db_level,
        output db_rise,
        output db_fall
    );
endinterface

// File: rtl/db_fsm_tick_sync_2ff.sv
// Two-flop synchronizer with synchronous active-high reset.
// Generic so that other pin inputs can reuse it.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability filter stage followed by the stable output stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/db_fsm_tick.sv
// Debounces one raw button using a periodic one-cycle tick as clock enable.
// Produces a clean level plus one-cycle rise/fall pulses, all registered on i_clk.
module db_fsm_tick
    import db_fsm_tick_pkg::*;
#(
    parameter int N_TICKS = N_TICKS_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    db_fsm_tick_if.slave  bus
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_TICKS - 1);

    logic             w_btn_s;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (bus.btn_in),
        .o_q   (w_btn_s)
    );

    // State, tick count and output registers; a bounce in a WAIT state wins over a tick.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_ZERO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                ST_ZERO: begin
                    if (w_btn_s) begin
                        r_state <= ST_WAIT1;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT1: begin
                    if (!w_btn_s) begin
                        r_state <= ST_ZERO;
                    end else if (bus.tick) begin
                        if (r_cnt == C_LAST) begin
                            r_state <= ST_ONE;
                            r_level <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_ONE: begin
                    if (!w_btn_s) begin
                        r_state <= ST_WAIT0;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT0: begin
                    if (w_btn_s) begin
                        r_state <= ST_ONE;
                    end else if (bus.tick) begin
                        if (r_cnt == C_LAST) begin
                            r_state <= ST_ZERO;
                            r_level <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_ZERO;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign bus.db_level = r_level;
    assign bus.db_rise  = r_rise;
    assign bus.db_fall  = r_fall;

endmodule
